// File: rtl/uart_prog_loader_pkg.sv
// Shared definitions for the UART program loader.
// Holds the FSM state encoding and the frame-format constants used by
// uart_prog_loader and its timeout counter.
package uart_prog_loader_pkg;

    // FSM states, 3-bit encoding.
    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_LEN_HI = 3'd1,
        ST_DATA   = 3'd2,
        ST_WRITE  = 3'd3,
        ST_DONE   = 3'd4
    } state_e;

    // Frame format: 2 length bytes (LE word count), then 4 bytes per word (LE).
    localparam int WORD_BYTES = 4;
    localparam int LEN_BYTES  = 2;
    localparam int LEN_W      = 8 * LEN_BYTES;
    localparam int BYTE_IDX_W = $clog2(WORD_BYTES);

endpackage

// File: rtl/uart_prog_loader_timeout_cnt.sv
// loader_timeout_cnt: inter-byte watchdog.
// Counts enabled, non-cleared cycles and pulses 'expired' in the cycle the
// count sits at TIMEOUT-1 with no clear. A clear in that same cycle wins.
// Ports:
//   clk, rst  - clock, synchronous active-high reset
//   clear     - zero the count (byte seen, or watchdog not armed)
//   enable    - count this cycle
//   expired   - one-cycle pulse on terminal count
module loader_timeout_cnt #(
    parameter int TIMEOUT = 1000000
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam int CNT_W = $clog2(TIMEOUT);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(TIMEOUT - 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        expired = enable && !clear && (cnt_q == LAST);
        cnt_d   = cnt_q;
        if (clear) begin
            cnt_d = '0;
        end else if (enable) begin
            // Restart after expiry so a standalone user sees periodic pulses.
            cnt_d = expired ? '0 : cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) cnt_q <= '0;
        else     cnt_q <= cnt_d;
    end

endmodule

// File: rtl/uart_prog_loader.sv
// uart_prog_loader: turns a uart_rx byte stream into instruction-memory writes.
// Frame: LEN_LO, LEN_HI (word count N), then 4*N little-endian data bytes.
// Holds the CPU while loading and aborts on an inter-byte timeout.
// Ports:
//   clk, rst              - clock, synchronous active-high reset
//   load_en               - gate for starting a new frame from IDLE
//   rx_data, rx_done_tick - byte and its one-cycle valid strobe
//   mem_we/addr/wdata     - one write per assembled word (addr wraps)
//   cpu_hold              - pipeline hold while a frame is in progress
//   load_done             - pulse in the DONE cycle
//   err_timeout           - sticky, frame aborted by inter-byte timeout
//   err_overrun           - sticky, byte arrived during WRITE or DONE
module uart_prog_loader
    import uart_prog_loader_pkg::*;
#(
    parameter int ADDR_W  = 10,
    parameter int TIMEOUT = 1000000
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load_en,
    input  logic [7:0]        rx_data,
    input  logic              rx_done_tick,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    output logic              cpu_hold,
    output logic              load_done,
    output logic              err_timeout,
    output logic              err_overrun
);

    // Word index must cover both the full 16-bit count and the address.
    localparam int IDX_W = (ADDR_W > LEN_W) ? ADDR_W : LEN_W;

    state_e                  state_q, state_d;
    logic [LEN_W-1:0]        len_q, len_d;
    logic [IDX_W-1:0]        word_idx_q, word_idx_d;
    logic [BYTE_IDX_W-1:0]   byte_idx_q, byte_idx_d;
    logic [31:0]             word_q, word_d;
    logic                    mem_we_q, mem_we_d;
    logic [ADDR_W-1:0]       mem_addr_q, mem_addr_d;
    logic [31:0]             mem_wdata_q, mem_wdata_d;
    logic                    cpu_hold_q, cpu_hold_d;
    logic                    load_done_q, load_done_d;
    logic                    err_to_q, err_to_d;
    logic                    err_ov_q, err_ov_d;

    logic tmo_en, tmo_clear, tmo_expired;

    // Watchdog is armed only while waiting for frame bytes; outside those
    // states it is held clear so every entry starts from zero.
    assign tmo_en    = (state_q == ST_LEN_HI) || (state_q == ST_DATA);
    assign tmo_clear = rx_done_tick || !tmo_en;

    loader_timeout_cnt #(.TIMEOUT(TIMEOUT)) u_tmo (
        .clk     (clk),
        .rst     (rst),
        .clear   (tmo_clear),
        .enable  (tmo_en),
        .expired (tmo_expired)
    );

    always_comb begin
        state_d     = state_q;
        len_d       = len_q;
        word_idx_d  = word_idx_q;
        byte_idx_d  = byte_idx_q;
        word_d      = word_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        cpu_hold_d  = cpu_hold_q;
        err_to_d    = err_to_q;
        err_ov_d    = err_ov_q;

        unique case (state_q)
            ST_IDLE: begin
                if (rx_done_tick && load_en) begin
                    len_d      = {8'h00, rx_data};
                    err_to_d   = 1'b0;
                    err_ov_d   = 1'b0;
                    cpu_hold_d = 1'b1;
                    state_d    = ST_LEN_HI;
                end
            end
            ST_LEN_HI: begin
                if (rx_done_tick) begin
                    len_d[15:8] = rx_data;
                    word_idx_d  = '0;
                    byte_idx_d  = '0;
                    state_d     = ({rx_data, len_q[7:0]} == '0) ? ST_DONE : ST_DATA;
                end else if (tmo_expired) begin
                    err_to_d   = 1'b1;
                    cpu_hold_d = 1'b0;
                    state_d    = ST_IDLE;
                end
            end
            ST_DATA: begin
                if (rx_done_tick) begin
                    word_d[byte_idx_q*8 +: 8] = rx_data;
                    if (byte_idx_q == BYTE_IDX_W'(WORD_BYTES - 1)) begin
                        byte_idx_d = '0;
                        state_d    = ST_WRITE;
                    end else begin
                        byte_idx_d = byte_idx_q + 1'b1;
                    end
                end else if (tmo_expired) begin
                    // Partial word is simply discarded.
                    err_to_d   = 1'b1;
                    cpu_hold_d = 1'b0;
                    state_d    = ST_IDLE;
                end
            end
            ST_WRITE: begin
                if (rx_done_tick) err_ov_d = 1'b1;
                word_idx_d = word_idx_q + 1'b1;
                state_d    = (word_idx_q == IDX_W'(len_q - 1'b1)) ? ST_DONE : ST_DATA;
            end
            ST_DONE: begin
                if (rx_done_tick) err_ov_d = 1'b1;
                cpu_hold_d = 1'b0;
                state_d    = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase

        // Outputs are registered off the next state so the strobes line up
        // with the cycle the FSM actually sits in WRITE / DONE.
        mem_we_d    = (state_d == ST_WRITE);
        load_done_d = (state_d == ST_DONE);
        if (state_d == ST_WRITE) begin
            mem_addr_d  = word_idx_q[ADDR_W-1:0];
            mem_wdata_d = word_d;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            len_q       <= '0;
            word_idx_q  <= '0;
            byte_idx_q  <= '0;
            word_q      <= '0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            cpu_hold_q  <= 1'b0;
            load_done_q <= 1'b0;
            err_to_q    <= 1'b0;
            err_ov_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            len_q       <= len_d;
            word_idx_q  <= word_idx_d;
            byte_idx_q  <= byte_idx_d;
            word_q      <= word_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            cpu_hold_q  <= cpu_hold_d;
            load_done_q <= load_done_d;
            err_to_q    <= err_to_d;
            err_ov_q    <= err_ov_d;
        end
    end

    assign mem_we      = mem_we_q;
    assign mem_addr    = mem_addr_q;
    assign mem_wdata   = mem_wdata_q;
    assign cpu_hold    = cpu_hold_q;
    assign load_done   = load_done_q;
    assign err_timeout = err_to_q;
    assign err_overrun = err_ov_q;

endmodule

// File: doc/uart_prog_loader.md
Name: uart_prog_loader

Overview:
Controller that sits behind uart_rx and sequences the received byte stream into 32-bit instruction-memory writes for the pipeline. It parses a length header, assembles little-endian words, and issues one write strobe per word. It holds the CPU (cpu_hold) while loading. It aborts on an inter-byte timeout so a broken transfer cannot hang the system.

Parameters:
ADDR_W, 10, instruction-memory word-address width
TIMEOUT, 1000000, clk cycles allowed between consecutive bytes once a frame has started (>=2)

Ports:
clk  in  1  system clock
rst  in  1  reset; one clock; reset is synchronous and active-high
load_en  in  1  when 0, bytes arriving in IDLE are ignored
rx_data  in  8  byte from uart_rx dout
rx_done_tick  in  1  one-cycle strobe from uart_rx; rx_data valid this cycle
mem_we  out  1  one-cycle write strobe to instruction memory
mem_addr  out  ADDR_W  word address, valid when mem_we=1
mem_wdata  out  32  assembled word, valid when mem_we=1
cpu_hold  out  1  stall/hold request to the pipeline during a load
load_done  out  1  one-cycle pulse when the last word is written
err_timeout  out  1  sticky: last frame aborted by timeout
err_overrun  out  1  sticky: byte arrived in a state that cannot accept it

Behaviour:
- Reset (sync, rst=1 at clk edge): state=IDLE. All outputs 0: mem_we, mem_addr, mem_wdata, cpu_hold, load_done, both err flags. Internal counters and the length register are 0. Reset mid-load abandons the frame; no write is issued.
- Frame format: LEN_LO, LEN_HI (16-bit word count N, little-endian), then 4*N data bytes. Each word is little-endian: the first byte goes to [7:0], the fourth to [31:24].
- "Byte" below means rx_done_tick=1 in that cycle. A byte is consumed in the same cycle.
- IDLE: on a byte with load_en=1:
  - latch len[7:0], clear both err flags, set cpu_hold=1, go to LEN_HI.
  - Bytes with load_en=0 are dropped with no flag change.
- LEN_HI: on a byte, latch len[15:8] and clear the word index and byte index.
  - If the full len == 0: go to DONE.
  - Otherwise: go to DATA.
- DATA: on a byte, shift it into the word assembly register at byte index (0..3).
  - Index < 3: increment the index and stay in DATA.
  - Index == 3: go to WRITE with the index reset to 0.
- WRITE: exactly one cycle, with mem_we=1, mem_addr=word index[ADDR_W-1:0], mem_wdata=assembled word.
  - Next cycle: increment the word index.
  - If word index == len-1: go to DONE. Otherwise return to DATA.
  - Word count N > 2^ADDR_W wraps the address modulo 2^ADDR_W; this is not an error.
- DONE: one cycle, with load_done=1. cpu_hold drops to 0 the following cycle. Then go to IDLE.
- Output registration:
  - mem_we, mem_addr, mem_wdata and load_done are registered: asserted in the cycle the FSM is in WRITE/DONE.
  - mem_wdata and mem_addr hold their last values when mem_we=0.
- Overrun: a byte arriving while in WRITE or DONE is dropped and err_overrun is set. The FSM is unaffected. (uart_rx frame spacing makes this impossible in the real system; it is defined for verification.)
- Timeout: in LEN_HI and DATA, a cycle counter is cleared on every consumed byte and on state entry, and increments otherwise.
  - When it reaches TIMEOUT-1 without a byte: set err_timeout, clear cpu_hold, go to IDLE. No partial word is written.
  - A byte in the same cycle as the terminal count wins, and no timeout occurs.
- The timeout counter width is clog2(TIMEOUT); it saturates nowhere else.
- Error flags stay set until the next accepted LEN_LO or rst.

Decomposition:
- Shared package/header: state encodings (IDLE, LEN_HI, DATA, WRITE, DONE as 3-bit localparams), WORD_BYTES=4, and the frame-format constants.
- One natural sub-module: loader_timeout_cnt. It takes clk, rst, clear, enable and produces an expired pulse, parameterised by TIMEOUT. It is reusable for a future uart_tx-side controller.

Test Plan:
- Normal load, TIMEOUT=100: bytes 02 00, 11 22 33 44, AA BB CC DD -> mem_we twice, (addr 0, 0x44332211) then (addr 1, 0xDDCCBBAA). Then one load_done pulse, cpu_hold 1 from the first byte until the cycle after DONE, and no error flags.
- Zero length: bytes 00 00 -> no mem_we, and load_done pulses in the cycle after LEN_HI is consumed. cpu_hold is high for exactly that span.
- Timeout: bytes 01 00 11 22, then silence -> 100 cycles after byte 22, err_timeout=1, cpu_hold=0 and state IDLE with no write. A new frame 01 00 01 02 03 04 clears err_timeout and writes 0x04030201 at addr 0.
- Gating and reset: load_en=0 with bytes 01 00 -> no hold, no writes. In a separate run, assert rst for one cycle mid-DATA -> all outputs 0 next cycle, and no write is issued for the partial word.
- Overrun and wrap, ADDR_W=2, frame N=5:
  - Words 0..4 are written to addresses 0,1,2,3,0.
  - Forcing rx_done_tick during a WRITE cycle sets err_overrun without corrupting the next word.
